jtag_scan_sequencer: RTL and testbench

JTAG master-side scan sequencer that drives the TMS/TDI pins of a TAP controller and collects TDO, turning one-word commands into complete IR scans, DR scans or TAP resets. It sits between a host-side command interface and the JTAG pins, runs on TCK, and keeps an internal mirror of the target TAP state. It always returns the TAP to Run-Test/Idle after each command.

---
 rtl/jtag_scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_sequencer.sv
// JTAG master scan sequencer: turns one-word commands into IR/DR scans or TAP resets,
// mirroring the target TAP state and always parking it in Run-Test/Idle.
module jtag_scan_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = $clog2(DATA_W) + 1
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_RESET,
  input  logic              CMD_IR,
  input  logic [LEN_W-1:0]  CMD_LEN,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA
);

  // Each state is the TAP state for the current cycle; Go and Idle both sit in RTI.
  typedef enum logic [3:0] {
    StTlr,
    StIdle,
    StGo,
    StSelDr,
    StSelIr,
    StCap,
    StShift,
    StExit1,
    StUpdate
  } state_e;

  typedef enum logic [1:0] {
    KindDr,
    KindIr,
    KindReset
  } kind_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(DATA_W);

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [LEN_W-1:0]   len_clamped;
  logic               last_bit;

  always_comb begin
    if (CMD_LEN == '0) begin
      len_clamped = LEN_W'(1);
    end else if (CMD_LEN > MaxLen) begin
      len_clamped = MaxLen;
    end else begin
      len_clamped = CMD_LEN;
    end
  end

  assign last_bit = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      StTlr: state_d = StIdle;
      StIdle: begin
        if (CMD_VALID) begin
          state_d = StGo;
          if (CMD_RESET) begin
            kind_d = KindReset;
          end else if (CMD_IR) begin
            kind_d = KindIr;
          end else begin
            kind_d = KindDr;
          end
          len_d = len_clamped;
          cnt_d = '0;
          sr_d  = CMD_DATA;
          cap_d = '0;
        end
      end
      StGo: state_d = StSelDr;
      StSelDr: state_d = (kind_q == KindDr) ? StCap : StSelIr;
      StSelIr: begin
        if (kind_q == KindReset) begin
          // The TLR cycle entered here completes the reset command.
          state_d     = StTlr;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
        end else begin
          state_d = StCap;
        end
      end
      StCap: state_d = StShift;
      StShift: begin
        for (int i = 0; i < DATA_W; i++) begin
          if (cnt_q == LEN_W'(i)) begin
            cap_d[i] = TDO;
          end
        end
        sr_d  = sr_q >> 1;
        cnt_d = cnt_q + LEN_W'(1);
        if (last_bit) begin
          state_d = StExit1;
        end
      end
      StExit1: begin
        state_d     = StUpdate;
        rsp_valid_d = 1'b1;
        rsp_data_d  = cap_q;
      end
      StUpdate: state_d = StIdle;
      default: state_d = StTlr;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q     <= StTlr;
      kind_q      <= KindDr;
      len_q       <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Pin outputs decode registered state only.
  always_comb begin
    TMS = 1'b0;
    case (state_q)
      StGo:    TMS = 1'b1;
      StSelDr: TMS = (kind_q != KindDr);
      StSelIr: TMS = (kind_q == KindReset);
      StShift: TMS = last_bit;
      StExit1: TMS = 1'b1;
      default: TMS = 1'b0;
    endcase
  end

  assign TDI       = (state_q == StShift) & sr_q[0];
  assign CMD_READY = (state_q == StIdle);
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Self-checking bench for jtag_scan_sequencer: table of directed commands against a TAP
// state-machine model, plus reset and mid-scan TRST sequences.
module tb_jtag_scan_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 6;

  logic              TCK = 1'b0;
  logic              TRST;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_RESET;
  logic              CMD_IR;
  logic [LEN_W-1:0]  CMD_LEN;
  logic [DATA_W-1:0] CMD_DATA;
  logic              TMS;
  logic              TDI;
  logic              TDO;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_DATA;
  logic              tdo_one;

  int checks   = 0;
  int failures = 0;

  jtag_scan_sequencer #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .TCK      (TCK),
    .TRST     (TRST),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_RESET(CMD_RESET),
    .CMD_IR   (CMD_IR),
    .CMD_LEN  (CMD_LEN),
    .CMD_DATA (CMD_DATA),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .RSP_VALID(RSP_VALID),
    .RSP_DATA (RSP_DATA)
  );

  always #5 TCK = ~TCK;

  assign TDO = tdo_one ? 1'b1 : TDI;

  // Target TAP controller model.
  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauseDr, TapEx2Dr, TapUpdDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauseIr, TapEx2Ir, TapUpdIr
  } tap_e;

  tap_e tap_st;

  always @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      tap_st <= TapTlr;
    end else begin
      case (tap_st)
        TapTlr:     tap_st <= TMS ? TapTlr   : TapRti;
        TapRti:     tap_st <= TMS ? TapSelDr : TapRti;
        TapSelDr:   tap_st <= TMS ? TapSelIr : TapCapDr;
        TapCapDr:   tap_st <= TMS ? TapEx1Dr : TapShDr;
        TapShDr:    tap_st <= TMS ? TapEx1Dr : TapShDr;
        TapEx1Dr:   tap_st <= TMS ? TapUpdDr : TapPauseDr;
        TapPauseDr: tap_st <= TMS ? TapEx2Dr : TapPauseDr;
        TapEx2Dr:   tap_st <= TMS ? TapUpdDr : TapShDr;
        TapUpdDr:   tap_st <= TMS ? TapSelDr : TapRti;
        TapSelIr:   tap_st <= TMS ? TapTlr   : TapCapIr;
        TapCapIr:   tap_st <= TMS ? TapEx1Ir : TapShIr;
        TapShIr:    tap_st <= TMS ? TapEx1Ir : TapShIr;
        TapEx1Ir:   tap_st <= TMS ? TapUpdIr : TapPauseIr;
        TapPauseIr: tap_st <= TMS ? TapEx2Ir : TapPauseIr;
        TapEx2Ir:   tap_st <= TMS ? TapUpdIr : TapShIr;
        TapUpdIr:   tap_st <= TMS ? TapSelDr : TapRti;
        default:    tap_st <= TapTlr;
      endcase
    end
  end

  typedef struct {
    logic              rst;
    logic              ir;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
    logic              tdo1;
    logic              hold;      // keep CMD_VALID high into the next command
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_tdi;   // TDI bits seen while the TAP is shifting
    logic [63:0]       exp_tms;   // bit k-1 = TMS in cycle k after accept
    int                rsp_cyc;
    int                rdy_cyc;
    int                shifts;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input int id, input string what, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d %s: got %0h, want %0h", id, what, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int                guard;
    int                first_rsp;
    int                n_rsp;
    int                rdy_cyc;
    int                n_shift;
    int                n_shir;
    int                n_cap;
    int                n_upd;
    int                n_tlr;
    logic [DATA_W-1:0] tdi_seen;
    logic [DATA_W-1:0] rsp_seen;
    logic [63:0]       tms_seen;
    guard = 0;
    first_rsp = -1; n_rsp = 0; rdy_cyc = -1;
    n_shift = 0; n_shir = 0; n_cap = 0; n_upd = 0; n_tlr = 0;
    tdi_seen = '0; rsp_seen = '0; tms_seen = '0;
    while (!CMD_READY && guard < 50) begin
      @(negedge TCK);
      guard++;
    end
    check(id, "ready_before_cmd", 64'(CMD_READY), 64'd1);
    CMD_VALID = 1'b1;
    CMD_RESET = v.rst;
    CMD_IR    = v.ir;
    CMD_LEN   = v.len;
    CMD_DATA  = v.data;
    tdo_one   = v.tdo1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge TCK);
      if (cyc == 1) begin
        check(id, "accepted_first_edge", 64'(CMD_READY), 64'd0);
        if (!v.hold) CMD_VALID = 1'b0;
      end
      tms_seen[cyc-1] = TMS;
      if (tap_st == TapShDr || tap_st == TapShIr) begin
        if (n_shift < DATA_W) tdi_seen[n_shift] = TDI;
        n_shift++;
      end
      if (tap_st == TapShIr) n_shir++;
      if (tap_st == TapCapDr || tap_st == TapCapIr) n_cap++;
      if (tap_st == TapUpdDr || tap_st == TapUpdIr) n_upd++;
      if (tap_st == TapTlr) n_tlr++;
      if (RSP_VALID) begin
        if (n_rsp == 0) begin
          first_rsp = cyc;
          rsp_seen  = RSP_DATA;
        end
        n_rsp++;
      end
      if (CMD_READY && cyc > 1) begin
        rdy_cyc = cyc;
        break;
      end
    end
    check(id, "ready_cycle", 64'(rdy_cyc), 64'(v.rdy_cyc));
    check(id, "rsp_cycle", 64'(first_rsp), 64'(v.rsp_cyc));
    check(id, "rsp_pulses", 64'(n_rsp), 64'd1);
    check(id, "rsp_data", 64'(rsp_seen), 64'(v.exp_data));
    check(id, "rsp_data_held", 64'(RSP_DATA), 64'(v.exp_data));
    check(id, "tms_seq", tms_seen, v.exp_tms);
    check(id, "tdi_bits", 64'(tdi_seen), 64'(v.exp_tdi));
    check(id, "shift_cycles", 64'(n_shift), 64'(v.shifts));
    check(id, "shift_ir_cycles", 64'(n_shir), 64'((v.ir && !v.rst) ? v.shifts : 0));
    check(id, "capture_cycles", 64'(n_cap), 64'(v.rst ? 0 : 1));
    check(id, "update_cycles", 64'(n_upd), 64'(v.rst ? 0 : 1));
    check(id, "tlr_cycles", 64'(n_tlr), 64'(v.rst ? 1 : 0));
    check(id, "tap_in_rti", 64'(tap_st), 64'(TapRti));
  endtask

  initial begin
    vec_t v_last;
    int   n_rsp;
    int   guard;
    //            rst   ir    len    data          tdo1  hold  exp_data      exp_tdi
    //            exp_tms                rsp rdy shifts
    vecs[0] = '{1'b0, 1'b0, 6'd8,  32'h0000_00A5, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_00A5,
                64'h0000_0000_0000_0C01, 13, 14, 8};
    vecs[1] = '{1'b0, 1'b1, 6'd4,  32'h0000_0003, 1'b1, 1'b0, 32'h0000_000F, 32'h0000_0003,
                64'h0000_0000_0000_0183, 10, 11, 4};
    vecs[2] = '{1'b1, 1'b1, 6'd8,  32'h0000_00FF, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000,
                64'h0000_0000_0000_0007, 4, 5, 0};
    vecs[3] = '{1'b0, 1'b0, 6'd32, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                64'h0000_000C_0000_0001, 37, 38, 32};
    vecs[4] = '{1'b0, 1'b0, 6'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001,
                64'h0000_0000_0000_0019, 6, 7, 1};
    vecs[5] = '{1'b0, 1'b0, 6'd40, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hCAFE_F00D,
                64'h0000_000C_0000_0001, 37, 38, 32};
    vecs[6] = '{1'b0, 1'b1, 6'd5,  32'h0000_0015, 1'b0, 1'b0, 32'h0000_0015, 32'h0000_0015,
                64'h0000_0000_0000_0303, 11, 12, 5};
    v_last  = '{1'b0, 1'b0, 6'd8,  32'h0000_005A, 1'b0, 1'b0, 32'h0000_005A, 32'h0000_005A,
                64'h0000_0000_0000_0C01, 13, 14, 8};

    TRST = 1'b0; CMD_VALID = 1'b0; CMD_RESET = 1'b0; CMD_IR = 1'b0;
    CMD_LEN = '0; CMD_DATA = '0; tdo_one = 1'b0;

    // Reset held, then released just after posedge 1: ready after posedge 2.
    repeat (3) @(negedge TCK);
    check(-1, "rst_tms", 64'(TMS), 64'd0);
    check(-1, "rst_tdi", 64'(TDI), 64'd0);
    check(-1, "rst_ready", 64'(CMD_READY), 64'd0);
    check(-1, "rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    check(-1, "rst_rsp_data", 64'(RSP_DATA), 64'd0);
    @(posedge TCK);
    #1 TRST = 1'b1;
    @(negedge TCK);
    check(-1, "rel_ready_c1", 64'(CMD_READY), 64'd0);
    check(-1, "rel_tap_tlr", 64'(tap_st), 64'(TapTlr));
    @(negedge TCK);
    check(-1, "rel_ready_c2", 64'(CMD_READY), 64'd1);
    check(-1, "rel_tap_rti", 64'(tap_st), 64'(TapRti));

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // TRST pulse in the 5th SHIFT cycle of a 16-bit DR scan.
    n_rsp = 0;
    CMD_VALID = 1'b1; CMD_RESET = 1'b0; CMD_IR = 1'b0;
    CMD_LEN = 6'd16; CMD_DATA = 32'h0000_BEEF; tdo_one = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge TCK);
      if (cyc == 1) CMD_VALID = 1'b0;
      if (RSP_VALID) n_rsp++;
    end
    check(7, "abort_in_shift", 64'(tap_st), 64'(TapShDr));
    TRST = 1'b0;
    #1;
    check(7, "abort_rsp_valid", 64'(RSP_VALID), 64'd0);
    check(7, "abort_rsp_data", 64'(RSP_DATA), 64'd0);
    check(7, "abort_tap_tlr", 64'(tap_st), 64'(TapTlr));
    check(7, "abort_tms", 64'(TMS), 64'd0);
    check(7, "abort_ready", 64'(CMD_READY), 64'd0);
    @(posedge TCK);
    #1 TRST = 1'b1;
    @(negedge TCK);
    check(7, "abort_tap_still_tlr", 64'(tap_st), 64'(TapTlr));
    guard = 0;
    while (!CMD_READY && guard < 20) begin
      if (RSP_VALID) n_rsp++;
      @(negedge TCK);
      guard++;
    end
    check(7, "abort_no_rsp", 64'(n_rsp), 64'd0);
    check(7, "abort_ready_back", 64'(CMD_READY), 64'd1);
    check(7, "abort_rsp_data_after", 64'(RSP_DATA), 64'd0);

    run_vec(8, v_last);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
